// File: rtl/throughput_monitor_mc.sv
// throughput_monitor_mc: per-channel windowed op counters with latched result/min/max and registered readout
module throughput_monitor_mc #(
  parameter int          NUM_CH         = 4,
  parameter int          COUNT_WIDTH    = 32,
  parameter int          WINDOW_WIDTH   = 32,
  parameter int unsigned DEFAULT_WINDOW = 27_000_000,
  parameter int          SEL_WIDTH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic                    clear_stats_i,
  input  logic [WINDOW_WIDTH-1:0] window_len_i,
  input  logic [NUM_CH-1:0]       op_valid_i,
  input  logic [SEL_WIDTH-1:0]    rd_sel_i,
  output logic [COUNT_WIDTH-1:0]  rd_result_o,
  output logic [COUNT_WIDTH-1:0]  rd_min_o,
  output logic [COUNT_WIDTH-1:0]  rd_max_o,
  output logic                    rd_sat_o,
  output logic                    window_done_o,
  output logic [15:0]             window_seq_o,
  output logic                    stats_valid_o
);
  localparam logic [COUNT_WIDTH-1:0]  ONES  = '1;
  localparam logic [WINDOW_WIDTH-1:0] ONE_W = WINDOW_WIDTH'(1);
  localparam logic [WINDOW_WIDTH-1:0] DEF_W = (DEFAULT_WINDOW == 0) ? ONE_W : WINDOW_WIDTH'(DEFAULT_WINDOW);
  logic [WINDOW_WIDTH-1:0] win_len_q, win_len_d, cyc_q;
  logic [COUNT_WIDTH-1:0]  cnt_q [NUM_CH];
  logic [COUNT_WIDTH-1:0]  final_d [NUM_CH];
  logic [COUNT_WIDTH-1:0]  result_q [NUM_CH];
  logic [COUNT_WIDTH-1:0]  min_q [NUM_CH];
  logic [COUNT_WIDTH-1:0]  max_q [NUM_CH];
  logic [NUM_CH-1:0]       sat_run_q, sat_d, sat_q;
  logic [COUNT_WIDTH-1:0]  rd_result_q, rd_min_q, rd_max_q;
  logic                    rd_sat_q, done_q, valid_q;
  logic [15:0]             seq_q;
  logic                    close, restart, sel_ok;

  always_comb begin
    win_len_d = (window_len_i == '0) ? ONE_W : window_len_i;
    close     = enable_i && !clear_stats_i && (cyc_q == win_len_q - ONE_W);
    restart   = close || !enable_i || clear_stats_i;
    sel_ok    = int'(rd_sel_i) < NUM_CH;
    final_d   = '{default: '0};
    sat_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      final_d[i] = (cnt_q[i] == ONES) ? cnt_q[i] : cnt_q[i] + COUNT_WIDTH'(op_valid_i[i]);
      sat_d[i]   = sat_run_q[i] | (op_valid_i[i] & (cnt_q[i] == ONES));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      win_len_q   <= DEF_W;
      cyc_q       <= '0;
      sat_run_q   <= '0;
      sat_q       <= '0;
      seq_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      rd_result_q <= '0;
      rd_min_q    <= ONES;
      rd_max_q    <= '0;
      rd_sat_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        result_q[i] <= '0;
        min_q[i]    <= ONES;
        max_q[i]    <= '0;
      end
    end else begin
      done_q <= close;
      cyc_q  <= restart ? '0 : cyc_q + ONE_W;
      if (restart) win_len_q <= win_len_d;
      if (clear_stats_i) begin
        seq_q   <= '0;
        valid_q <= 1'b0;
      end else if (close) begin
        seq_q   <= seq_q + 16'd1;
        valid_q <= 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= restart ? '0 : final_d[i];
        sat_run_q[i] <= !restart && sat_d[i];
        if (clear_stats_i) begin
          result_q[i] <= '0;
          sat_q[i]    <= 1'b0;
          min_q[i]    <= ONES;
          max_q[i]    <= '0;
        end else if (close) begin
          result_q[i] <= final_d[i];
          sat_q[i]    <= sat_d[i];
          min_q[i]    <= (final_d[i] < min_q[i]) ? final_d[i] : min_q[i];
          max_q[i]    <= (final_d[i] > max_q[i]) ? final_d[i] : max_q[i];
        end
      end
      rd_result_q <= sel_ok ? result_q[rd_sel_i] : '0;
      rd_min_q    <= sel_ok ? min_q[rd_sel_i] : '0;
      rd_max_q    <= sel_ok ? max_q[rd_sel_i] : '0;
      rd_sat_q    <= sel_ok ? sat_q[rd_sel_i] : 1'b0;
    end
  end

  assign rd_result_o   = rd_result_q;
  assign rd_min_o      = rd_min_q;
  assign rd_max_o      = rd_max_q;
  assign rd_sat_o      = rd_sat_q;
  assign window_done_o = done_q;
  assign window_seq_o  = seq_q;
  assign stats_valid_o = valid_q;
endmodule

// File: tb/tb_throughput_monitor_mc.sv
// tb_throughput_monitor_mc: directed scenario tasks against a 4-channel/32-bit and a 3-channel/4-bit instance
module tb_throughput_monitor_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int passed = 0;
  int total = 0;
  logic        a_en, a_clr;
  logic [31:0] a_len;
  logic [3:0]  a_op;
  logic [1:0]  a_sel;
  logic [31:0] a_res, a_min, a_max;
  logic        a_sat, a_done, a_valid;
  logic [15:0] a_seq;
  logic        b_en, b_clr;
  logic [7:0]  b_len;
  logic [2:0]  b_op;
  logic [1:0]  b_sel;
  logic [3:0]  b_res, b_min, b_max;
  logic        b_sat, b_done, b_valid;
  logic [15:0] b_seq;

  throughput_monitor_mc #(.NUM_CH(4), .COUNT_WIDTH(32), .WINDOW_WIDTH(32), .DEFAULT_WINDOW(8)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(a_en), .clear_stats_i(a_clr), .window_len_i(a_len),
    .op_valid_i(a_op), .rd_sel_i(a_sel), .rd_result_o(a_res), .rd_min_o(a_min), .rd_max_o(a_max),
    .rd_sat_o(a_sat), .window_done_o(a_done), .window_seq_o(a_seq), .stats_valid_o(a_valid));

  throughput_monitor_mc #(.NUM_CH(3), .COUNT_WIDTH(4), .WINDOW_WIDTH(8), .DEFAULT_WINDOW(20)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(b_en), .clear_stats_i(b_clr), .window_len_i(b_len),
    .op_valid_i(b_op), .rd_sel_i(b_sel), .rd_result_o(b_res), .rd_min_o(b_min), .rd_max_o(b_max),
    .rd_sat_o(b_sat), .window_done_o(b_done), .window_seq_o(b_seq), .stats_valid_o(b_valid));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    a_en = 0; a_clr = 0; a_len = 32'd10; a_op = '0; a_sel = '0;
    b_en = 0; b_clr = 0; b_len = 8'd20; b_op = '0; b_sel = '0;
    rst_n = 0;
    step(1);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (a_res !== 32'd0) $display("FAIL reset_result got %0d exp 0", a_res); else passed++;
    total++; if (a_min !== 32'hFFFF_FFFF) $display("FAIL reset_min got %h exp ffffffff", a_min); else passed++;
    total++; if (a_max !== 32'd0) $display("FAIL reset_max got %0d exp 0", a_max); else passed++;
    total++; if (a_sat !== 1'b0) $display("FAIL reset_sat got %b exp 0", a_sat); else passed++;
    total++; if (a_done !== 1'b0) $display("FAIL reset_done got %b exp 0", a_done); else passed++;
    total++; if (a_seq !== 16'd0) $display("FAIL reset_seq got %0d exp 0", a_seq); else passed++;
    total++; if (a_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", a_valid); else passed++;
    total++; if (b_min !== 4'hF) $display("FAIL reset_b_min got %h exp f", b_min); else passed++;
  endtask

  task automatic test_default_window();
    do_reset();
    a_en = 1; a_op = 4'b0001;
    step(7);
    total++; if (a_done !== 1'b0) $display("FAIL defwin_early got %b exp 0", a_done); else passed++;
    step(1);
    total++; if (a_done !== 1'b1) $display("FAIL defwin_done got %b exp 1", a_done); else passed++;
    total++; if (a_seq !== 16'd1) $display("FAIL defwin_seq got %0d exp 1", a_seq); else passed++;
    total++; if (a_valid !== 1'b1) $display("FAIL defwin_valid got %b exp 1", a_valid); else passed++;
    step(1);
    total++; if (a_done !== 1'b0) $display("FAIL defwin_done_pulse got %b exp 0", a_done); else passed++;
    total++; if (a_res !== 32'd8) $display("FAIL defwin_result got %0d exp 8", a_res); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    step(1);
    a_en = 1;
    for (int k = 0; k < 10; k++) begin
      a_op = {k == 9, 1'b0, (k % 2) == 0, 1'b1};
      if (k == 9) begin
        total++; if (a_done !== 1'b0) $display("FAIL basic_early got %b exp 0", a_done); else passed++;
      end
      step(1);
    end
    a_op = '0;
    total++; if (a_done !== 1'b1) $display("FAIL basic_done got %b exp 1", a_done); else passed++;
    total++; if (a_seq !== 16'd1) $display("FAIL basic_seq got %0d exp 1", a_seq); else passed++;
    step(1);
    total++; if (a_res !== 32'd10) $display("FAIL basic_ch0 got %0d exp 10", a_res); else passed++;
    a_sel = 2'd1;
    step(1);
    total++; if (a_res !== 32'd5) $display("FAIL basic_ch1 got %0d exp 5", a_res); else passed++;
    total++; if (a_min !== 32'd5) $display("FAIL basic_ch1_min got %0d exp 5", a_min); else passed++;
    total++; if (a_max !== 32'd5) $display("FAIL basic_ch1_max got %0d exp 5", a_max); else passed++;
    a_sel = 2'd2;
    step(1);
    total++; if (a_res !== 32'd0) $display("FAIL basic_ch2 got %0d exp 0", a_res); else passed++;
    a_sel = 2'd3;
    step(1);
    total++; if (a_res !== 32'd1) $display("FAIL closing_op_ch3 got %0d exp 1", a_res); else passed++;
    step(6);
    total++; if (a_done !== 1'b1) $display("FAIL basic_done2 got %b exp 1", a_done); else passed++;
    total++; if (a_seq !== 16'd2) $display("FAIL basic_seq2 got %0d exp 2", a_seq); else passed++;
    step(1);
    total++; if (a_res !== 32'd0) $display("FAIL closing_op_next got %0d exp 0", a_res); else passed++;
    total++; if (a_min !== 32'd0) $display("FAIL closing_op_min got %0d exp 0", a_min); else passed++;
    total++; if (a_max !== 32'd1) $display("FAIL closing_op_max got %0d exp 1", a_max); else passed++;
  endtask

  task automatic test_minmax_clear();
    int cnts [3] = '{4, 7, 2};
    do_reset();
    step(1);
    a_en = 1;
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 10; k++) begin
        a_op = {3'b000, k < cnts[w]};
        step(1);
      end
    a_op = '0;
    total++; if (a_seq !== 16'd3) $display("FAIL minmax_seq got %0d exp 3", a_seq); else passed++;
    step(1);
    total++; if (a_res !== 32'd2) $display("FAIL minmax_result got %0d exp 2", a_res); else passed++;
    total++; if (a_min !== 32'd2) $display("FAIL minmax_min got %0d exp 2", a_min); else passed++;
    total++; if (a_max !== 32'd7) $display("FAIL minmax_max got %0d exp 7", a_max); else passed++;
    a_clr = 1;
    step(1);
    a_clr = 0;
    total++; if (a_seq !== 16'd0) $display("FAIL clear_seq got %0d exp 0", a_seq); else passed++;
    total++; if (a_valid !== 1'b0) $display("FAIL clear_valid got %b exp 0", a_valid); else passed++;
    step(1);
    total++; if (a_min !== 32'hFFFF_FFFF) $display("FAIL clear_min got %h exp ffffffff", a_min); else passed++;
    total++; if (a_max !== 32'd0) $display("FAIL clear_max got %0d exp 0", a_max); else passed++;
    total++; if (a_res !== 32'd0) $display("FAIL clear_result got %0d exp 0", a_res); else passed++;
  endtask

  task automatic test_len_change();
    do_reset();
    step(1);
    a_en = 1;
    step(3);
    a_len = 32'd5;
    step(6);
    total++; if (a_done !== 1'b0) $display("FAIL lenchg_early got %b exp 0", a_done); else passed++;
    step(1);
    total++; if (a_done !== 1'b1) $display("FAIL lenchg_first10 got %b exp 1", a_done); else passed++;
    step(4);
    total++; if (a_done !== 1'b0) $display("FAIL lenchg_mid5 got %b exp 0", a_done); else passed++;
    step(1);
    total++; if (a_done !== 1'b1) $display("FAIL lenchg_next5 got %b exp 1", a_done); else passed++;
    a_len = 32'd0;
    step(5);
    total++; if (a_done !== 1'b1) $display("FAIL len0_last5 got %b exp 1", a_done); else passed++;
    for (int k = 0; k < 4; k++) begin
      step(1);
      total++; if (a_done !== 1'b1) $display("FAIL len0_every got %b exp 1", a_done); else passed++;
    end
    total++; if (a_seq !== 16'd7) $display("FAIL len0_seq got %0d exp 7", a_seq); else passed++;
  endtask

  task automatic test_enable_drop();
    do_reset();
    step(1);
    a_en = 1; a_op = 4'b0001;
    step(10);
    total++; if (a_done !== 1'b1) $display("FAIL endrop_w1 got %b exp 1", a_done); else passed++;
    step(6);
    a_en = 0;
    step(4);
    total++; if (a_done !== 1'b0) $display("FAIL endrop_done got %b exp 0", a_done); else passed++;
    total++; if (a_seq !== 16'd1) $display("FAIL endrop_seq got %0d exp 1", a_seq); else passed++;
    total++; if (a_res !== 32'd10) $display("FAIL endrop_result got %0d exp 10", a_res); else passed++;
    a_en = 1;
    for (int k = 0; k < 10; k++) begin
      a_op = {3'b000, k < 3};
      if (k == 9) begin
        total++; if (a_done !== 1'b0) $display("FAIL reen_early got %b exp 0", a_done); else passed++;
      end
      step(1);
    end
    a_op = '0;
    total++; if (a_done !== 1'b1) $display("FAIL reen_done got %b exp 1", a_done); else passed++;
    total++; if (a_seq !== 16'd2) $display("FAIL reen_seq got %0d exp 2", a_seq); else passed++;
    step(1);
    total++; if (a_res !== 32'd3) $display("FAIL reen_result got %0d exp 3", a_res); else passed++;
    total++; if (a_min !== 32'd3) $display("FAIL reen_min got %0d exp 3", a_min); else passed++;
    total++; if (a_max !== 32'd10) $display("FAIL reen_max got %0d exp 10", a_max); else passed++;
  endtask

  task automatic test_reset_mid();
    a_en = 1; a_op = 4'b0001;
    step(4);
    rst_n = 0;
    step(1);
    rst_n = 1;
    total++; if (a_res !== 32'd0) $display("FAIL rstmid_result got %0d exp 0", a_res); else passed++;
    total++; if (a_min !== 32'hFFFF_FFFF) $display("FAIL rstmid_min got %h exp ffffffff", a_min); else passed++;
    total++; if (a_max !== 32'd0) $display("FAIL rstmid_max got %0d exp 0", a_max); else passed++;
    total++; if (a_seq !== 16'd0) $display("FAIL rstmid_seq got %0d exp 0", a_seq); else passed++;
    total++; if (a_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", a_valid); else passed++;
  endtask

  task automatic test_clear_on_close();
    do_reset();
    step(1);
    a_en = 1; a_op = 4'b0001;
    step(9);
    a_clr = 1;
    step(1);
    a_clr = 0;
    total++; if (a_done !== 1'b0) $display("FAIL clrclose_done got %b exp 0", a_done); else passed++;
    total++; if (a_seq !== 16'd0) $display("FAIL clrclose_seq got %0d exp 0", a_seq); else passed++;
    step(9);
    total++; if (a_done !== 1'b0) $display("FAIL clrclose_early got %b exp 0", a_done); else passed++;
    step(1);
    total++; if (a_done !== 1'b1) $display("FAIL clrclose_restart got %b exp 1", a_done); else passed++;
    step(1);
    total++; if (a_res !== 32'd10) $display("FAIL clrclose_result got %0d exp 10", a_res); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    b_en = 1;
    for (int k = 0; k < 40; k++) begin
      b_op = {1'b0, k < 14, k < 23};
      if (k == 20) begin
        total++; if (b_done !== 1'b1) $display("FAIL sat_done got %b exp 1", b_done); else passed++;
      end
      if (k == 21) begin
        total++; if (b_res !== 4'd15) $display("FAIL sat_result got %0d exp 15", b_res); else passed++;
        total++; if (b_sat !== 1'b1) $display("FAIL sat_flag got %b exp 1", b_sat); else passed++;
      end
      step(1);
    end
    b_op = '0;
    total++; if (b_seq !== 16'd2) $display("FAIL sat_seq got %0d exp 2", b_seq); else passed++;
    step(1);
    total++; if (b_res !== 4'd3) $display("FAIL unsat_result got %0d exp 3", b_res); else passed++;
    total++; if (b_sat !== 1'b0) $display("FAIL unsat_flag got %b exp 0", b_sat); else passed++;
    total++; if (b_min !== 4'd3) $display("FAIL sat_min got %0d exp 3", b_min); else passed++;
    total++; if (b_max !== 4'd15) $display("FAIL sat_max got %0d exp 15", b_max); else passed++;
    b_sel = 2'd3;
    step(1);
    total++; if (b_res !== 4'd0) $display("FAIL oob_result got %0d exp 0", b_res); else passed++;
    total++; if (b_min !== 4'd0) $display("FAIL oob_min got %0d exp 0", b_min); else passed++;
    total++; if (b_max !== 4'd0) $display("FAIL oob_max got %0d exp 0", b_max); else passed++;
    b_sel = 2'd1;
    step(1);
    total++; if (b_max !== 4'd14) $display("FAIL ch1_max got %0d exp 14", b_max); else passed++;
    total++; if (b_min !== 4'd0) $display("FAIL ch1_min got %0d exp 0", b_min); else passed++;
    total++; if (b_sat !== 1'b0) $display("FAIL ch1_sat got %b exp 0", b_sat); else passed++;
  endtask

  initial begin
    test_reset();
    test_default_window();
    test_basic();
    test_minmax_clear();
    test_len_change();
    test_enable_drop();
    test_reset_mid();
    test_clear_on_close();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/throughput_monitor_mc.md
# throughput_monitor_mc

Multi-channel, runtime-configurable throughput monitor for ATOMiK hardware demos. It counts per-channel completed operations over a programmable window, latches per-window results, and tracks per-channel min/max since the last statistics clear. Per-channel results are exposed through a registered readout mux. It sits beside the datapath blocks and feeds the UART/LED reporting logic, one channel per monitored engine.

## Interface
- NUM_CH, 4: number of monitored channels (≥1).
- COUNT_WIDTH, 32: width of per-channel op counters, results, min and max.
- WINDOW_WIDTH, 32: width of window length and window cycle counter.
- DEFAULT_WINDOW, 27_000_000: window length loaded at reset (1 s at 27 MHz).
- SEL_WIDTH, $clog2(NUM_CH) (min 1): readout select width.
- clk  in  1  system clock; one clock domain; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  monitoring enable.
- clear_stats  in  1  single-cycle pulse: clear stats and restart the window.
- window_len  in  WINDOW_WIDTH  window length in cycles; a value of 0 is treated as 1.
- op_valid  in  NUM_CH  per-channel completion pulse; bit i is channel i.
- rd_sel  in  SEL_WIDTH  channel to read.
- rd_result  out  COUNT_WIDTH  selected channel's last complete window count.
- rd_min  out  COUNT_WIDTH  selected channel's minimum window count since clear.
- rd_max  out  COUNT_WIDTH  selected channel's maximum window count since clear.
- rd_sat  out  1  selected channel saturated in the last complete window.
- window_done  out  1  one-cycle pulse when a window closes.
- window_seq  out  16  count of windows closed since clear; wraps.
- stats_valid  out  1  at least one window has closed since clear.

## Operation
- Internal state:
  - win_len_q: active window length.
  - cyc: window cycle counter.
  - cnt[i]: per-channel op counter.
  - sat_run[i]: per-channel running saturation flag.
  - result[i], sat[i], min[i], max[i]: latched per-channel statistics.
- win_len_q loads max(window_len, 1) at every window restart: window close, enable low, or clear_stats.
  - A window_len change mid-window takes effect at the next window.
  - Reset loads DEFAULT_WINDOW.
- Control priority, highest first: rst_n low, clear_stats, enable low, normal counting.
- rst_n low, and clear_stats in any state:
  - Clears cyc, cnt, sat_run, result, sat, max, window_seq and stats_valid.
  - Sets min to all-ones.
  - Drops any partially counted window.
- enable low: cyc, cnt and sat_run are held at 0. result, min, max, window_seq and stats_valid are held.
- Normal counting, each enabled cycle:
  - cnt[i] increments when op_valid[i] is high.
  - At all-ones, cnt[i] holds and sets sat_run[i].
- Window close occurs when cyc == win_len_q−1 in an enabled cycle.
  - Final count is cnt[i] plus op_valid[i] that cycle, saturating.
  - result[i] ← final count; sat[i] ← sat_run[i] OR'd with saturation that cycle.
  - min[i] ← min(min[i], final); max[i] ← max(max[i], final).
  - window_seq increments; stats_valid ← 1.
  - cyc, cnt and sat_run return to 0. An op on the closing cycle counts only in the closing window.
- Readout: rd_* register the selected channel's result, min, max and sat. rd_sel ≥ NUM_CH returns all zeros.

## Timing
- Reset values:
  - rd_result, rd_max, rd_sat, window_done, window_seq and stats_valid are 0.
  - rd_min is all-ones.
- A window spans exactly win_len_q enabled cycles; enable-low cycles restart it and are not counted.
- window_done is high on the cycle after the closing cycle. In that same cycle, result, min, max, sat, window_seq and stats_valid show the new values.
- rd_* latency:
  - 1 cycle after an rd_sel change.
  - 2 cycles after the closing cycle for new window data, i.e. one cycle after window_done.
- With window_len = 1 (or 0), window_done is high every cycle after the first enabled cycle.
- window_seq wraps from 0xFFFF to 0 with no flag.
- clear_stats on a closing cycle wins: that window is discarded and window_done stays low next cycle.

## Test plan
- NUM_CH=2, window_len=10, ch0 op every cycle, ch1 every other cycle → window_done pulses after 10 enabled cycles; rd_result is 10 for ch0 and 5 for ch1; window_seq=1.
- COUNT_WIDTH=4, window_len=20, ch0 continuous ops → rd_result=15, rd_sat=1. Next window with 3 ops → rd_result=3, rd_sat=0.
- Three windows with ch0 counts 4, 7, 2 → rd_min=2, rd_max=7, window_seq=3. Then clear_stats → rd_min all-ones, rd_max=0, stats_valid=0.
- window_len changes 10→5 at cycle 3 of a window → that window closes at 10 cycles, subsequent windows at 5. window_len=0 → window_done every cycle.
- Op on the closing cycle is counted in the closing window: next-window count starts at 0.
- Interruptions mid-window:
  - enable dropped at cycle 6 of a 10-cycle window → no window_done, results unchanged; re-enable gives a full 10 cycles.
  - rst_n asserted mid-window → all outputs at reset values next cycle.
  - rd_sel=3 with NUM_CH=3 → all rd_* zero.
